// File: rtl/cla_nibble_serial_adder.sv
// cla_nibble_serial_adder: WIDTH-bit adder that time-shares one 4-bit
// carry-look-ahead slice across all nibbles, LSB first, one nibble per clock.
// The carry between nibbles is held in a register, so there is no
// combinational path across nibbles.
// Optional feature macro: CLA_SUB_EN adds the i_sub port (a - b via ~b + 1).
// WIDTH must be a multiple of 4 and at least 4.

// 4-bit carry-look-ahead slice: p/g generate, flat c1..c4 look-ahead, s = p ^ c.
module cla4_slice (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_c0,
  output logic [3:0] o_s,
  output logic       o_c4
);
  logic [3:0] w_p, w_g;
  logic [4:0] w_c;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;

  // Each carry is a flat sum of products, with no ripple inside the slice.
  assign w_c[0] = i_c0;
  assign w_c[1] = w_g[0] | (w_p[0] & i_c0);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c0);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_c0);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_c0);

  assign o_s  = w_p ^ w_c[3:0];
  assign o_c4 = w_c[4];
endmodule

module cla_nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
`ifdef CLA_SUB_EN
  input  logic             i_sub,
`endif
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                      r_state, w_state_nxt;
  logic [NIBBLES-1:0][3:0]     r_a, r_b, r_psum, w_psum_nxt;
  logic                        r_carry;
  logic [IDXW-1:0]             r_idx;
  logic [WIDTH-1:0]            r_sum;
  logic                        r_cout;
  logic [3:0]                  w_s;
  logic                        w_c4;
  logic                        w_last;
  logic                        w_sub;

`ifdef CLA_SUB_EN
  assign w_sub = i_sub;
`else
  assign w_sub = 1'b0;
`endif

  // The single shared slice; the nibble mux in front of it plus the slice
  // itself form the critical path, independent of WIDTH.
  cla4_slice u_slice (
    .i_a  (r_a[r_idx]),
    .i_b  (r_b[r_idx]),
    .i_c0 (r_carry),
    .o_s  (w_s),
    .o_c4 (w_c4)
  );

  assign w_last = (r_idx == LAST_IDX);

  // Partial sum with the current nibble merged in; also the final result on the last nibble.
  always_comb begin
    w_psum_nxt        = r_psum;
    w_psum_nxt[r_idx] = w_s;
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic: start only matters in IDLE and is never queued.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_start) w_state_nxt = RUN;
      RUN:     if (w_last)  w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: capture on accept, one nibble per RUN cycle, result load on the last nibble.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_psum  <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (i_start) begin
          r_a     <= i_a;
          // Subtraction is a + ~b + 1; cin is ignored then.
          r_b     <= w_sub ? ~i_b : i_b;
          r_carry <= w_sub ? 1'b1 : i_cin;
          r_idx   <= '0;
          r_psum  <= '0;
        end
        RUN: begin
          r_psum  <= w_psum_nxt;
          r_carry <= w_c4;
          r_idx   <= w_last ? '0 : r_idx + 1'b1;
          if (w_last) begin
            r_sum  <= w_psum_nxt;
            r_cout <= w_c4;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy = (r_state == RUN);
  assign o_done = (r_state == DONE);
  assign o_sum  = r_sum;
  assign o_cout = r_cout;
endmodule
